// File: rtl/weight_load_if.sv
// Weight load controller bus.
// Groups the load request/status handshake, the weight memory read port and
// the weight register bank write port. The controller connects through the
// slave modport; the requester/memory/bank side uses the master modport.
interface weight_load_if #(
   parameter int LAYER_W = 4,
   parameter int DATA_W  = 8
);
   // Request side
   logic               start;
   logic [LAYER_W-1:0] layer;
   logic               abort;

   // Weight memory read port
   logic               mem_rd;
   logic [LAYER_W+1:0] mem_addr;
   logic [DATA_W-1:0]  mem_data;

   // Weight register bank write port
   logic               wb_write;
   logic [1:0]         wb_addr;
   logic [DATA_W-1:0]  wb_data;

   // Status
   logic               busy;
   logic               done;
   logic               loaded_valid;
   logic [LAYER_W-1:0] loaded_layer;

   modport master (
      output start, layer, abort, mem_data,
      input  mem_rd, mem_addr, wb_write, wb_addr, wb_data,
      input  busy, done, loaded_valid, loaded_layer
   );

   modport slave (
      input  start, layer, abort, mem_data,
      output mem_rd, mem_addr, wb_write, wb_addr, wb_data,
      output busy, done, loaded_valid, loaded_layer
   );
endinterface

// File: rtl/weight_load_ctrl.sv
// Weight load controller.
// Copies the 4 weights of one layer from the weight memory into the 4-unit
// weight register bank. Reads are issued on 4 consecutive cycles; memory data
// returns one cycle later and is forwarded straight to the bank, so the writes
// trail the reads by one cycle and a one-cycle FLUSH state covers the last
// write. A request for the layer already resident in the bank is answered
// with a done pulse and no memory traffic.
module weight_load_ctrl #(
   parameter int LAYER_W = 4,
   parameter int DATA_W  = 8
) (
   input logic          clk,
   input logic          reset,
   weight_load_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   state_t             state;
   logic [LAYER_W-1:0] cur_layer;
   logic               mem_rd_q;
   logic [LAYER_W+1:0] mem_addr_q;
   logic               wb_write_q;
   logic [1:0]         wb_addr_q;
   logic               done_q;
   logic               loaded_valid_q;
   logic [LAYER_W-1:0] loaded_layer_q;
   logic               cache_hit;
   logic [DATA_W-1:0]  wb_data_c;

   // A request hits when the bank already holds every weight of that layer.
   assign cache_hit = loaded_valid_q && (bus.layer == loaded_layer_q);

   // Load sequencer: the low two address bits double as the read index k, and
   // each write targets the unit whose read was issued in the previous cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cur_layer      <= '0;
         mem_rd_q       <= 1'b0;
         mem_addr_q     <= '0;
         wb_write_q     <= 1'b0;
         wb_addr_q      <= '0;
         done_q         <= 1'b0;
         loaded_valid_q <= 1'b0;
         loaded_layer_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (cache_hit) begin
                     done_q <= 1'b1;
                  end else begin
                     state          <= RUN;
                     cur_layer      <= bus.layer;
                     loaded_valid_q <= 1'b0;
                     mem_rd_q       <= 1'b1;
                     mem_addr_q     <= {bus.layer, 2'b00};
                  end
               end
            end
            RUN: begin
               if (bus.abort) begin
                  state      <= IDLE;
                  mem_rd_q   <= 1'b0;
                  mem_addr_q <= '0;
                  wb_write_q <= 1'b0;
                  wb_addr_q  <= '0;
               end else begin
                  wb_write_q <= 1'b1;
                  wb_addr_q  <= mem_addr_q[1:0];
                  if (mem_addr_q[1:0] == 2'd3) begin
                     state      <= FLUSH;
                     mem_rd_q   <= 1'b0;
                     mem_addr_q <= '0;
                  end else begin
                     mem_addr_q <= {mem_addr_q[LAYER_W+1:2], mem_addr_q[1:0] + 2'd1};
                  end
               end
            end
            FLUSH: begin
               state      <= IDLE;
               wb_write_q <= 1'b0;
               wb_addr_q  <= '0;
               if (!bus.abort) begin
                  done_q         <= 1'b1;
                  loaded_valid_q <= 1'b1;
                  loaded_layer_q <= cur_layer;
               end
            end
            default: begin
               state      <= IDLE;
               mem_rd_q   <= 1'b0;
               mem_addr_q <= '0;
               wb_write_q <= 1'b0;
               wb_addr_q  <= '0;
            end
         endcase
      end
   end

   // Memory read data goes to the bank unregistered, aligned with wb_write.
   assign wb_data_c = bus.mem_data;

   assign bus.mem_rd       = mem_rd_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.wb_write     = wb_write_q;
   assign bus.wb_addr      = wb_addr_q;
   assign bus.wb_data      = wb_data_c;
   assign bus.busy         = (state != IDLE);
   assign bus.done         = done_q;
   assign bus.loaded_valid = loaded_valid_q;
   assign bus.loaded_layer = loaded_layer_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Testbench for weight_load_ctrl.
// A small memory model answers reads one cycle after mem_rd. Each scenario
// pushes the reads and writes it expects (with their cycle) onto scoreboard
// queues and pops them as the DUT produces strobes.
module tb_weight_load_ctrl;
   localparam int LAYER_W = 4;
   localparam int DATA_W  = 8;

   typedef struct {
      int                 cyc;
      logic [LAYER_W+1:0] addr;
   } rd_t;

   typedef struct {
      int                cyc;
      logic [1:0]        unit;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic clk;
   logic reset;

   weight_load_if #(.LAYER_W(LAYER_W), .DATA_W(DATA_W)) bus ();

   weight_load_ctrl #(.LAYER_W(LAYER_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DATA_W-1:0] mem [0:(1 << (LAYER_W + 2)) - 1];
   rd_t exp_rd[$];
   wr_t exp_wr[$];
   int  cyc;
   int  n_checks;
   int  n_fail;

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle; the memory model returns the word read in the cycle
   // just finished.
   task automatic tick();
      logic               rd;
      logic [LAYER_W+1:0] a;
      rd = bus.mem_rd;
      a  = bus.mem_addr;
      @(posedge clk);
      #1;
      cyc++;
      bus.mem_data = (rd === 1'b1) ? mem[a] : '0;
   endtask

   // Queue the reads/writes a load of lyr started at cycle t should produce.
   function automatic void push_load(int t, logic [LAYER_W-1:0] lyr, int n_rd, int n_wr);
      rd_t r;
      wr_t w;
      for (int k = 0; k < n_rd; k++) begin
         r.cyc  = t + 1 + k;
         r.addr = {lyr, 2'(k)};
         exp_rd.push_back(r);
      end
      for (int k = 0; k < n_wr; k++) begin
         w.cyc  = t + 2 + k;
         w.unit = 2'(k);
         w.data = mem[{lyr, 2'(k)}];
         exp_wr.push_back(w);
      end
   endfunction

   task automatic test_reset();
      reset        = 1'b1;
      bus.start    = 1'b1;
      bus.layer    = 4'd3;
      bus.abort    = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.mem_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_rd: got %b, required 0", bus.mem_rd); end
      n_checks++;
      if (bus.mem_addr !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %0d, required 0", bus.mem_addr); end
      n_checks++;
      if (bus.wb_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wb_write: got %b, required 0", bus.wb_write); end
      n_checks++;
      if (bus.wb_addr !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_wb_addr: got %0d, required 0", bus.wb_addr); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b, required 0", bus.done); end
      n_checks++;
      if (bus.loaded_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_loaded_valid: got %b, required 0", bus.loaded_valid); end
      n_checks++;
      if (bus.loaded_layer !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_loaded_layer: got %0d, required 0", bus.loaded_layer); end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      reset     = 1'b0;
      tick();
   endtask

   task automatic test_full_load();
      rd_t  r;
      wr_t  w;
      logic due;
      $display("[TB] full load of layer 2");
      bus.layer = 4'd2;
      bus.start = 1'b1;
      push_load(cyc, 4'd2, 4, 4);
      for (int j = 1; j <= 7; j++) begin
         tick();
         bus.start = 1'b0;
         due = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
         n_checks++;
         if (bus.mem_rd !== due) begin n_fail++; $display("[TB] FAIL full_mem_rd T+%0d: got %b, required %b", j, bus.mem_rd, due); end
         if (due) begin
            r = exp_rd.pop_front();
            n_checks++;
            if (bus.mem_addr !== r.addr) begin n_fail++; $display("[TB] FAIL full_mem_addr T+%0d: got %0d, required %0d", j, bus.mem_addr, r.addr); end
         end
         due = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
         n_checks++;
         if (bus.wb_write !== due) begin n_fail++; $display("[TB] FAIL full_wb_write T+%0d: got %b, required %b", j, bus.wb_write, due); end
         if (due) begin
            w = exp_wr.pop_front();
            n_checks++;
            if ({bus.wb_addr, bus.wb_data} !== {w.unit, w.data}) begin n_fail++; $display("[TB] FAIL full_wb T+%0d: got unit %0d data %h, required unit %0d data %h", j, bus.wb_addr, bus.wb_data, w.unit, w.data); end
         end
         if (!bus.busy) begin
            n_checks++;
            if (bus.wb_addr !== 2'd0) begin n_fail++; $display("[TB] FAIL full_idle_wb_addr T+%0d: got %0d, required 0", j, bus.wb_addr); end
         end
         n_checks++;
         if (bus.busy !== (j <= 5)) begin n_fail++; $display("[TB] FAIL full_busy T+%0d: got %b, required %b", j, bus.busy, (j <= 5)); end
         n_checks++;
         if (bus.done !== (j == 6)) begin n_fail++; $display("[TB] FAIL full_done T+%0d: got %b, required %b", j, bus.done, (j == 6)); end
         n_checks++;
         if (bus.loaded_valid !== (j >= 6)) begin n_fail++; $display("[TB] FAIL full_loaded_valid T+%0d: got %b, required %b", j, bus.loaded_valid, (j >= 6)); end
      end
      n_checks++;
      if (exp_rd.size() + exp_wr.size() != 0) begin n_fail++; $display("[TB] FAIL full_leftover: got %0d pending, required 0", exp_rd.size() + exp_wr.size()); end
      n_checks++;
      if (bus.loaded_layer !== 4'd2) begin n_fail++; $display("[TB] FAIL full_loaded_layer: got %0d, required 2", bus.loaded_layer); end
      exp_rd.delete();
      exp_wr.delete();
   endtask

   task automatic test_cache_hit();
      $display("[TB] repeat request for layer 2");
      bus.layer = 4'd2;
      bus.start = 1'b1;
      for (int j = 1; j <= 3; j++) begin
         tick();
         bus.start = 1'b0;
         n_checks++;
         if (bus.mem_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_mem_rd T+%0d: got %b, required 0", j, bus.mem_rd); end
         n_checks++;
         if (bus.wb_write !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_wb_write T+%0d: got %b, required 0", j, bus.wb_write); end
         n_checks++;
         if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_busy T+%0d: got %b, required 0", j, bus.busy); end
         n_checks++;
         if (bus.done !== (j == 1)) begin n_fail++; $display("[TB] FAIL hit_done T+%0d: got %b, required %b", j, bus.done, (j == 1)); end
         n_checks++;
         if (bus.loaded_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hit_loaded_valid T+%0d: got %b, required 1", j, bus.loaded_valid); end
      end
   endtask

   task automatic test_back_to_back();
      rd_t  r;
      wr_t  w;
      logic due;
      $display("[TB] load layer 15 with start pulses while busy");
      bus.layer = 4'd15;
      bus.start = 1'b1;
      push_load(cyc, 4'd15, 4, 4);
      for (int j = 1; j <= 9; j++) begin
         tick();
         if (j == 1) bus.start = 1'b0;
         if (j == 2) begin bus.start = 1'b1; bus.layer = 4'd5; end
         if (j == 4) bus.start = 1'b0;
         due = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
         n_checks++;
         if (bus.mem_rd !== due) begin n_fail++; $display("[TB] FAIL b2b_mem_rd T+%0d: got %b, required %b", j, bus.mem_rd, due); end
         if (due) begin
            r = exp_rd.pop_front();
            n_checks++;
            if (bus.mem_addr !== r.addr) begin n_fail++; $display("[TB] FAIL b2b_mem_addr T+%0d: got %0d, required %0d", j, bus.mem_addr, r.addr); end
         end
         due = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
         n_checks++;
         if (bus.wb_write !== due) begin n_fail++; $display("[TB] FAIL b2b_wb_write T+%0d: got %b, required %b", j, bus.wb_write, due); end
         if (due) begin
            w = exp_wr.pop_front();
            n_checks++;
            if ({bus.wb_addr, bus.wb_data} !== {w.unit, w.data}) begin n_fail++; $display("[TB] FAIL b2b_wb T+%0d: got unit %0d data %h, required unit %0d data %h", j, bus.wb_addr, bus.wb_data, w.unit, w.data); end
         end
         n_checks++;
         if (bus.busy !== (j <= 5)) begin n_fail++; $display("[TB] FAIL b2b_busy T+%0d: got %b, required %b", j, bus.busy, (j <= 5)); end
         n_checks++;
         if (bus.done !== (j == 6)) begin n_fail++; $display("[TB] FAIL b2b_done T+%0d: got %b, required %b", j, bus.done, (j == 6)); end
         n_checks++;
         if (bus.loaded_valid !== (j >= 6)) begin n_fail++; $display("[TB] FAIL b2b_loaded_valid T+%0d: got %b, required %b", j, bus.loaded_valid, (j >= 6)); end
      end
      n_checks++;
      if (exp_rd.size() + exp_wr.size() != 0) begin n_fail++; $display("[TB] FAIL b2b_leftover: got %0d pending, required 0", exp_rd.size() + exp_wr.size()); end
      n_checks++;
      if (bus.loaded_layer !== 4'd15) begin n_fail++; $display("[TB] FAIL b2b_loaded_layer: got %0d, required 15", bus.loaded_layer); end
      exp_rd.delete();
      exp_wr.delete();
   endtask

   task automatic test_abort();
      rd_t  r;
      wr_t  w;
      logic due;
      $display("[TB] abort a load of layer 7, then reload it");
      bus.layer = 4'd7;
      bus.start = 1'b1;
      push_load(cyc, 4'd7, 3, 2);
      for (int j = 1; j <= 6; j++) begin
         tick();
         if (j == 1) bus.start = 1'b0;
         if (j == 3) bus.abort = 1'b1;
         if (j == 4) bus.abort = 1'b0;
         due = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
         n_checks++;
         if (bus.mem_rd !== due) begin n_fail++; $display("[TB] FAIL abort_mem_rd T+%0d: got %b, required %b", j, bus.mem_rd, due); end
         if (due) begin
            r = exp_rd.pop_front();
            n_checks++;
            if (bus.mem_addr !== r.addr) begin n_fail++; $display("[TB] FAIL abort_mem_addr T+%0d: got %0d, required %0d", j, bus.mem_addr, r.addr); end
         end
         due = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
         n_checks++;
         if (bus.wb_write !== due) begin n_fail++; $display("[TB] FAIL abort_wb_write T+%0d: got %b, required %b", j, bus.wb_write, due); end
         if (due) begin
            w = exp_wr.pop_front();
            n_checks++;
            if ({bus.wb_addr, bus.wb_data} !== {w.unit, w.data}) begin n_fail++; $display("[TB] FAIL abort_wb T+%0d: got unit %0d data %h, required unit %0d data %h", j, bus.wb_addr, bus.wb_data, w.unit, w.data); end
         end
         n_checks++;
         if (bus.busy !== (j <= 3)) begin n_fail++; $display("[TB] FAIL abort_busy T+%0d: got %b, required %b", j, bus.busy, (j <= 3)); end
         n_checks++;
         if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done T+%0d: got %b, required 0", j, bus.done); end
         n_checks++;
         if (bus.loaded_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_loaded_valid T+%0d: got %b, required 0", j, bus.loaded_valid); end
      end
      n_checks++;
      if (exp_rd.size() + exp_wr.size() != 0) begin n_fail++; $display("[TB] FAIL abort_leftover: got %0d pending, required 0", exp_rd.size() + exp_wr.size()); end
      exp_rd.delete();
      exp_wr.delete();

      // Same layer again, with abort held alongside start in IDLE.
      bus.layer = 4'd7;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      push_load(cyc, 4'd7, 4, 4);
      for (int j = 1; j <= 7; j++) begin
         tick();
         bus.start = 1'b0;
         bus.abort = 1'b0;
         due = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
         n_checks++;
         if (bus.mem_rd !== due) begin n_fail++; $display("[TB] FAIL reload_mem_rd T+%0d: got %b, required %b", j, bus.mem_rd, due); end
         if (due) begin
            r = exp_rd.pop_front();
            n_checks++;
            if (bus.mem_addr !== r.addr) begin n_fail++; $display("[TB] FAIL reload_mem_addr T+%0d: got %0d, required %0d", j, bus.mem_addr, r.addr); end
         end
         due = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
         n_checks++;
         if (bus.wb_write !== due) begin n_fail++; $display("[TB] FAIL reload_wb_write T+%0d: got %b, required %b", j, bus.wb_write, due); end
         if (due) begin
            w = exp_wr.pop_front();
            n_checks++;
            if ({bus.wb_addr, bus.wb_data} !== {w.unit, w.data}) begin n_fail++; $display("[TB] FAIL reload_wb T+%0d: got unit %0d data %h, required unit %0d data %h", j, bus.wb_addr, bus.wb_data, w.unit, w.data); end
         end
         n_checks++;
         if (bus.done !== (j == 6)) begin n_fail++; $display("[TB] FAIL reload_done T+%0d: got %b, required %b", j, bus.done, (j == 6)); end
      end
      n_checks++;
      if (exp_rd.size() + exp_wr.size() != 0) begin n_fail++; $display("[TB] FAIL reload_leftover: got %0d pending, required 0", exp_rd.size() + exp_wr.size()); end
      n_checks++;
      if ({bus.loaded_valid, bus.loaded_layer} !== {1'b1, 4'd7}) begin n_fail++; $display("[TB] FAIL reload_loaded: got valid %b layer %0d, required valid 1 layer 7", bus.loaded_valid, bus.loaded_layer); end
      exp_rd.delete();
      exp_wr.delete();
   endtask

   task automatic test_reset_midload();
      rd_t  r;
      wr_t  w;
      logic due;
      $display("[TB] reset during a load of layer 4");
      bus.layer = 4'd4;
      bus.start = 1'b1;
      push_load(cyc, 4'd4, 4, 3);
      for (int j = 1; j <= 7; j++) begin
         tick();
         if (j == 1) bus.start = 1'b0;
         if (j == 4) reset = 1'b1;
         if (j == 5) begin
            reset = 1'b0;
            n_checks++;
            if ({bus.mem_addr, bus.wb_addr, bus.loaded_layer} !== '0) begin n_fail++; $display("[TB] FAIL midreset_values: got mem_addr %0d wb_addr %0d loaded_layer %0d, required all 0", bus.mem_addr, bus.wb_addr, bus.loaded_layer); end
         end
         due = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
         n_checks++;
         if (bus.mem_rd !== due) begin n_fail++; $display("[TB] FAIL midreset_mem_rd T+%0d: got %b, required %b", j, bus.mem_rd, due); end
         if (due) begin
            r = exp_rd.pop_front();
            n_checks++;
            if (bus.mem_addr !== r.addr) begin n_fail++; $display("[TB] FAIL midreset_mem_addr T+%0d: got %0d, required %0d", j, bus.mem_addr, r.addr); end
         end
         due = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
         n_checks++;
         if (bus.wb_write !== due) begin n_fail++; $display("[TB] FAIL midreset_wb_write T+%0d: got %b, required %b", j, bus.wb_write, due); end
         if (due) begin
            w = exp_wr.pop_front();
            n_checks++;
            if ({bus.wb_addr, bus.wb_data} !== {w.unit, w.data}) begin n_fail++; $display("[TB] FAIL midreset_wb T+%0d: got unit %0d data %h, required unit %0d data %h", j, bus.wb_addr, bus.wb_data, w.unit, w.data); end
         end
         n_checks++;
         if (bus.busy !== (j <= 4)) begin n_fail++; $display("[TB] FAIL midreset_busy T+%0d: got %b, required %b", j, bus.busy, (j <= 4)); end
         n_checks++;
         if ({bus.done, bus.loaded_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL midreset_done_valid T+%0d: got %b%b, required 00", j, bus.done, bus.loaded_valid); end
      end
      n_checks++;
      if (exp_rd.size() + exp_wr.size() != 0) begin n_fail++; $display("[TB] FAIL midreset_leftover: got %0d pending, required 0", exp_rd.size() + exp_wr.size()); end
      exp_rd.delete();
      exp_wr.delete();

      // A fresh request after reset runs as a normal full load.
      bus.layer = 4'd4;
      bus.start = 1'b1;
      push_load(cyc, 4'd4, 4, 4);
      for (int j = 1; j <= 7; j++) begin
         tick();
         bus.start = 1'b0;
         due = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
         n_checks++;
         if (bus.mem_rd !== due) begin n_fail++; $display("[TB] FAIL postreset_mem_rd T+%0d: got %b, required %b", j, bus.mem_rd, due); end
         if (due) begin
            r = exp_rd.pop_front();
            n_checks++;
            if (bus.mem_addr !== r.addr) begin n_fail++; $display("[TB] FAIL postreset_mem_addr T+%0d: got %0d, required %0d", j, bus.mem_addr, r.addr); end
         end
         due = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
         n_checks++;
         if (bus.wb_write !== due) begin n_fail++; $display("[TB] FAIL postreset_wb_write T+%0d: got %b, required %b", j, bus.wb_write, due); end
         if (due) begin
            w = exp_wr.pop_front();
            n_checks++;
            if ({bus.wb_addr, bus.wb_data} !== {w.unit, w.data}) begin n_fail++; $display("[TB] FAIL postreset_wb T+%0d: got unit %0d data %h, required unit %0d data %h", j, bus.wb_addr, bus.wb_data, w.unit, w.data); end
         end
         n_checks++;
         if (bus.done !== (j == 6)) begin n_fail++; $display("[TB] FAIL postreset_done T+%0d: got %b, required %b", j, bus.done, (j == 6)); end
      end
      n_checks++;
      if (exp_rd.size() + exp_wr.size() != 0) begin n_fail++; $display("[TB] FAIL postreset_leftover: got %0d pending, required 0", exp_rd.size() + exp_wr.size()); end
      n_checks++;
      if ({bus.loaded_valid, bus.loaded_layer} !== {1'b1, 4'd4}) begin n_fail++; $display("[TB] FAIL postreset_loaded: got valid %b layer %0d, required valid 1 layer 4", bus.loaded_valid, bus.loaded_layer); end
      exp_rd.delete();
      exp_wr.delete();
   endtask

   // Scenario sequence.
   initial begin
      n_checks     = 0;
      n_fail       = 0;
      cyc          = 0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.layer    = '0;
      bus.abort    = 1'b0;
      bus.mem_data = '0;
      for (int i = 0; i < (1 << (LAYER_W + 2)); i++) begin
         mem[i] = 8'(i * 13 + 5);
      end
      mem[8]  = 8'h11;
      mem[9]  = 8'h22;
      mem[10] = 8'h33;
      mem[11] = 8'h44;

      test_reset();
      test_full_load();
      test_cache_hit();
      test_back_to_back();
      test_abort();
      test_reset_midload();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
